param_pipeline_addsub: RTL
==========================

PARAM_PIPELINE_ADDSUB -- requirements
Module: param_pipeline_addsub

Interface
REQ-001 Parameter DATA_W, default 32, operand and result width in bits.
REQ-002 Parameter STAGES, default 4, number of pipeline stages; the adder is split into STAGES slices of SLICE_W = DATA_W/STAGES bits.
REQ-003 The block SHALL support DATA_W divisible by STAGES with STAGES in 1..8; other values SHALL stop elaboration with an error.
REQ-004 clk  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 flush  in  1  synchronous clear of all in-flight operations.
REQ-007 in_valid  in  1  the operand beat is valid.
REQ-008 in_ready  out  1  the block can accept an operand beat.
REQ-009 cin_a  in  DATA_W  operand A.
REQ-010 cin_b  in  DATA_W  operand B.
REQ-011 c_in  in  1  carry-in (add) or borrow-in (subtract).
REQ-012 sub  in  1  0 = add, 1 = subtract.
REQ-013 out_valid  out  1  the result beat is valid.
REQ-014 out_ready  in  1  the consumer accepts the result beat.
REQ-015 sum  out  DATA_W  result.
REQ-016 c_out  out  1  carry out of bit DATA_W-1.
REQ-017 overflow  out  1  two's-complement overflow flag (see Configuration).

Function
REQ-018 An operand beat SHALL be accepted in a cycle where in_valid and in_ready are both 1.
REQ-019 sub=0: result SHALL be {c_out,sum} = A + B + c_in.
REQ-020 sub=1: result SHALL be {c_out,sum} = A + ~B + ~c_in, which gives A - B - c_in; c_out=1 means no borrow.
REQ-021 Stage k (0-based) SHALL add slice k of A and B (B already inverted when sub=1) plus the carry registered by stage k-1. Stage 0 SHALL use the effective carry-in.
REQ-022 Each stage SHALL register:
- its slice sum;
- the lower slices already computed;
- the untouched upper operand slices;
- the carry;
- a valid bit.
REQ-023 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when the pipeline is not stalled.
REQ-024 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-025 Stage k SHALL advance when it is empty or stage k+1 advances. The last stage SHALL advance when it is empty or out_ready=1.
REQ-026 in_ready SHALL equal "stage 0 advances". It is combinational from out_ready and the valid bits.
REQ-027 Stalled stages SHALL hold all registered values. Bubbles SHALL be squeezed out: an empty stage SHALL accept from the stage above even while later stages are stalled.
REQ-028 sum, c_out and overflow SHALL be stable while out_valid=1 and out_ready=0.
REQ-029 Beats SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-030 flush=1 SHALL clear every valid bit at the next edge.
REQ-031 flush SHALL take priority over acceptance in the same cycle: a beat presented with in_valid=1 and in_ready=1 during flush SHALL be discarded. in_ready SHALL remain as defined in REQ-026.
REQ-032 Carry-out SHALL wrap modulo 2^DATA_W in sum, with the excess reported on c_out only.

Reset
REQ-033 While rst=0, every valid bit, carry, data register and overflow register SHALL be 0.
REQ-034 During reset, out_valid=0, sum=0, c_out=0 and overflow=0.
REQ-035 Reset assertion mid-operation SHALL discard all in-flight beats immediately, without waiting for a clock.
REQ-036 The first acceptance after reset release SHALL be possible on the first rising edge with rst=1.

Configuration
REQ-037 Macro PIPE_ADDSUB_OVERFLOW_EN controls the overflow flag.
- Defined: overflow SHALL be registered alongside the top slice and equal carry-into-MSB XOR carry-out-of-MSB for the result beat.
- Undefined: overflow SHALL be tied to 0 and no overflow logic SHALL be generated.

Verification
REQ-038 Default parameters: add 0xFFFFFFFF + 0x00000001, c_in=0, out_ready=1 -> 4 cycles later sum=0x00000000, c_out=1, overflow=0.
REQ-039 sub=1: A=0x00000005, B=0x00000007, c_in=0 -> sum=0xFFFFFFFE, c_out=0. With the macro defined, A=0x80000000, B=0x00000001 -> sum=0x7FFFFFFF, overflow=1.
REQ-040 Back-pressure: stream 8 consecutive beats, hold out_ready=0 for 6 cycles after the first result -> in_ready falls once all 4 stages are full, first result held stable, all 8 results in order with no loss.
REQ-041 Flush with 3 beats in flight and in_valid=1 -> out_valid=0 next cycle, none of the 4 beats emerge, the next accepted beat has latency 4.
REQ-042 Assert rst low asynchronously between clock edges with a full pipeline -> out_valid and sum go to 0 before the next edge; after release the first beat completes in 4 cycles.
REQ-043 DATA_W=64, STAGES=8: random 1000 beats with random in_valid/out_ready -> every result matches the reference model of REQ-019/020.

Source files
------------

// File: rtl/param_pipeline_addsub.sv
// Ready/valid pipelined adder/subtractor. Each stage adds one DATA_W/STAGES-bit slice.
// The overflow flag is generated only when PIPE_ADDSUB_OVERFLOW_EN is defined.
module param_pipeline_addsub #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] cin_a,
  input  logic [DATA_W-1:0] cin_b,
  input  logic              c_in,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic              c_out,
  output logic              overflow
);
  localparam int unsigned SLICE_W = (STAGES == 0) ? DATA_W : DATA_W / STAGES;
  localparam int unsigned LAST    = (STAGES == 0) ? 0 : STAGES - 1;

  generate
    if (STAGES < 1 || STAGES > 8 || (DATA_W % SLICE_W) != 0 || SLICE_W * STAGES != DATA_W) begin : g_bad_cfg
      $error("param_pipeline_addsub: need STAGES in 1..8 and DATA_W divisible by STAGES");
    end
  endgenerate

  logic              valid_q [STAGES];
  logic              valid_d [STAGES];
  logic              carry_q [STAGES];
  logic              carry_d [STAGES];
  logic [DATA_W-1:0] res_q   [STAGES];
  logic [DATA_W-1:0] res_d   [STAGES];
  logic [DATA_W-1:0] a_q     [STAGES];
  logic [DATA_W-1:0] a_d     [STAGES];
  logic [DATA_W-1:0] b_q     [STAGES];
  logic [DATA_W-1:0] b_d     [STAGES];

  logic              adv     [STAGES];
  logic              ld      [STAGES];
  logic              v_src   [STAGES];
  logic              c_src   [STAGES];
  logic [DATA_W-1:0] a_src   [STAGES];
  logic [DATA_W-1:0] b_src   [STAGES];
  logic [DATA_W-1:0] r_src   [STAGES];
  logic [SLICE_W:0]  slice   [STAGES];

  // Stage inputs, advance chain (from the output backwards) and per-slice add
  always_comb begin
    v_src   = '{default: 1'b0};
    c_src   = '{default: 1'b0};
    a_src   = '{default: '0};
    b_src   = '{default: '0};
    r_src   = '{default: '0};
    adv     = '{default: 1'b0};
    ld      = '{default: 1'b0};
    slice   = '{default: '0};
    valid_d = valid_q;
    carry_d = carry_q;
    res_d   = res_q;
    a_d     = a_q;
    b_d     = b_q;

    v_src[0] = in_valid;
    c_src[0] = sub ? ~c_in : c_in;
    a_src[0] = cin_a;
    b_src[0] = sub ? ~cin_b : cin_b;
    for (int k = 1; k < int'(STAGES); k++) begin
      v_src[k] = valid_q[k-1];
      c_src[k] = carry_q[k-1];
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      r_src[k] = res_q[k-1];
    end

    adv[LAST] = ~valid_q[LAST] | out_ready;
    for (int k = int'(LAST) - 1; k >= 0; k--) begin
      adv[k] = ~valid_q[k] | adv[k+1];
    end

    for (int k = 0; k < int'(STAGES); k++) begin
      slice[k] = {1'b0, a_src[k][k*SLICE_W +: SLICE_W]}
               + {1'b0, b_src[k][k*SLICE_W +: SLICE_W]}
               + {{SLICE_W{1'b0}}, c_src[k]};
      ld[k]      = adv[k] & v_src[k] & ~flush;
      valid_d[k] = flush ? 1'b0 : (adv[k] ? v_src[k] : valid_q[k]);
      if (ld[k]) begin
        res_d[k]                      = r_src[k];
        res_d[k][k*SLICE_W +: SLICE_W] = slice[k][SLICE_W-1:0];
        carry_d[k]                    = slice[k][SLICE_W];
        a_d[k]                        = a_src[k];
        b_d[k]                        = b_src[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        res_q[k]   <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        valid_q[k] <= valid_d[k];
        carry_q[k] <= carry_d[k];
        res_q[k]   <= res_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
      end
    end
  end

`ifdef PIPE_ADDSUB_OVERFLOW_EN
  logic ovf_q;
  logic ovf_d;

  // Carry into the MSB is recovered as a ^ b ^ sum at that bit
  always_comb begin
    ovf_d = ovf_q;
    if (ld[LAST]) begin
      ovf_d = a_src[LAST][DATA_W-1] ^ b_src[LAST][DATA_W-1]
            ^ slice[LAST][SLICE_W-1] ^ slice[LAST][SLICE_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign in_ready  = adv[0];
  assign out_valid = valid_q[LAST];
  assign sum       = res_q[LAST];
  assign c_out     = carry_q[LAST];
endmodule
